// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Shares one asynchronous SRAM between the CPU memory path and the
// debug/program-loader port. A requester raises req and holds it; the
// arbiter grants one port, latches its operands, drives the SRAM strobes
// for a fixed number of cycles and then returns a one-cycle ready pulse.
// Simultaneous requests are resolved round-robin.
//
// Ports:
//   Clk, Reset                 rising-edge clock, synchronous active-high reset
//   cpu_req / dbg_req          level request, held until the matching ready
//   cpu_we  / dbg_we           1 = write, 0 = read
//   cpu_addr / dbg_addr        access address
//   cpu_wdata / dbg_wdata      write data
//   cpu_rdata / dbg_rdata      registered read data, updated on read completion
//   cpu_ready / dbg_ready      one-cycle completion pulse
//   sram_addr                  registered SRAM address
//   sram_dq_out, sram_dq_oe    write data and drive enable for the tristate pad
//   sram_dq_in                 data returned from the pad
//   sram_ce_n/oe_n/we_n        registered active-low SRAM strobes
//   busy                       high whenever an access is in progress

module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,

  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter is loaded with ACCESS_CYCLES-1 and counts down to zero, so
  // the ACCESS state lasts exactly ACCESS_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [3:0]          cnt;
  logic                owner_dbg;
  logic                last_dbg;
  logic                lat_we;

  logic                grant;
  logic                grant_dbg;
  logic                last_cycle;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Next-state and grant decision. A tie goes to the port that did not win
  // the previous grant; a lone request always wins.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_dbg  = 1'b0;
    last_cycle = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant      = 1'b1;
          next_state = ACCESS;
          if (cpu_req && dbg_req) begin
            grant_dbg = ~last_dbg;
          end else begin
            grant_dbg = dbg_req;
          end
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          last_cycle = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand mux for the port being granted this cycle.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dbg) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operands are captured only at grant so the requester may change them
  // freely afterwards. The pointer starts at DBG so the CPU wins the first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= 4'd0;
      owner_dbg   <= 1'b0;
      last_dbg    <= 1'b1;
      lat_we      <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if (grant) begin
      cnt         <= CNT_LOAD;
      owner_dbg   <= grant_dbg;
      last_dbg    <= grant_dbg;
      lat_we      <= sel_we;
      sram_addr   <= sel_addr;
      sram_dq_out <= sel_wdata;
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Strobes are set on the grant edge and cleared on the edge that leaves
  // ACCESS, so they stay constant for the whole access with no OE/WE overlap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else if (grant) begin
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= sel_we;
      sram_we_n  <= ~sel_we;
      sram_dq_oe <= sel_we;
    end else if (last_cycle) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end
  end

  // Read data is sampled from the pad on the last ACCESS cycle and ready is
  // raised for the owning port, so both appear together in DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_ready <= last_cycle && !owner_dbg;
      dbg_ready <= last_cycle && owner_dbg;
      if (last_cycle && !lat_we) begin
        if (owner_dbg) begin
          dbg_rdata <= sram_dq_in;
        end else begin
          cpu_rdata <= sram_dq_in;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences and shares the single asynchronous SRAM between two requesters: the CPU memory path (instruction fetch, LDR and STR through MAR/MDR) and the debug/program-loader port. It generates the SRAM control strobes with a fixed, parameterised access length, so the control FSM only raises a request and waits for a one-cycle ready pulse instead of counting wait states. Each access is latched at grant, runs to completion, and then returns to idle. Ties between the requesters are resolved round-robin.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 3, cycles strobes are held active per access (legal range 1..15)

- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, level; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ready: same directions, widths and meanings, for the debug/loader port
- sram_addr  out  ADDR_W  registered SRAM address
- sram_dq_out  out  DATA_W  write data to the tristate pad
- sram_dq_oe  out  1  pad drive enable, 1 = drive sram_dq_out
- sram_dq_in  in  DATA_W  data from the pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- busy  out  1  high whenever state is not IDLE

## Operation
- States:
  - IDLE: if any req is high, grant one requester. Latch that requester's addr, we and wdata, load the access counter with ACCESS_CYCLES-1, and go to ACCESS. If no req is high, stay in IDLE.
  - ACCESS: decrement the counter each cycle. On the cycle the counter is 0, go to DONE.
  - DONE: pulse the granted port's ready, then go to IDLE unconditionally.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The last-granted pointer updates at each grant.
  - After reset, the pointer is set so the CPU wins the first tie.
- Strobes, all registered, asserted only in ACCESS:
  - sram_ce_n = 0 for every access.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - Write: sram_oe_n = 1, sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = latched wdata.
  - In IDLE and DONE: sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_dq_oe = 0.
- sram_addr holds the latched address from grant through DONE. In IDLE it is not updated.
- Read data:
  - sram_dq_in is captured into the granted port's rdata register on the last ACCESS cycle (counter = 0).
  - It is therefore valid in the DONE cycle, together with ready.
  - It holds until that port's next read completes.
  - Writes never change rdata.
- Requester rules:
  - Operands are sampled only at grant; changes after grant are ignored.
  - A requester deasserts req in the cycle after it sees ready. If req is still high when the arbiter returns to IDLE, a new access begins (back-to-back is allowed).
- Reset, including reset in the middle of an access:
  - State goes to IDLE and all strobes go inactive on the next edge.
  - The aborted access produces no ready pulse.

## Timing
- Reset values:
  - sram_ce_n, sram_oe_n, sram_we_n = 1
  - sram_dq_oe = 0, sram_dq_out = 0, sram_addr = 0
  - cpu_rdata, dbg_rdata = 0
  - cpu_ready, dbg_ready = 0
  - busy = 0
- Latency: req first seen high at edge k (in IDLE) gives strobes active for cycles k+1 .. k+ACCESS_CYCLES, and ready high in cycle k+ACCESS_CYCLES+1.
- Occupancy: ACCESS_CYCLES+2 cycles per access, including the return through IDLE. With the default of 3, a continuous stream is one access per 5 cycles.
- Ready is exactly one cycle wide and never asserted on both ports in the same cycle.
- The strobe pattern is constant across all ACCESS cycles: no glitching between cycles and no OE/WE overlap.

## Test plan
- CPU read only: cpu_req=1, we=0, addr=0x00012, sram_dq_in=0xBEEF → ce_n/oe_n low for 3 cycles, we_n=1, cpu_ready pulses on cycle 4, cpu_rdata=0xBEEF, dbg_rdata unchanged.
- Debug write: dbg_req=1, we=1, addr=0x0FFFF, wdata=0x1234 → we_n low and dq_oe=1 for 3 cycles, sram_dq_out=0x1234, oe_n=1 throughout, dbg_ready on cycle 4, no rdata change.
- Simultaneous requests held high after reset → grants alternate CPU, DBG, CPU, DBG. Each access takes 5 cycles. Ready pulses alternate ports.
- Operand change after grant: cpu_addr goes 0x10 → 0x20 one cycle after grant → sram_addr stays 0x10 through DONE.
- Reset asserted in the 2nd ACCESS cycle of a write → next cycle all strobes inactive, dq_oe=0, busy=0, no ready pulse. A new request afterward completes normally.
- ACCESS_CYCLES=1 build: CPU read → strobes for 1 cycle, ready 2 cycles after the req edge, correct data captured.
